// File: rtl/cva6_mem_arb_pkg.sv
// Shared types and requester indices for the memory request arbiter and its TID pool.
// Requester index order fixes the round-robin order after reset (icache first).
package cva6_mem_arb_pkg;

    localparam int unsigned OWNER_W = 4;

    localparam int unsigned REQ_ICACHE    = 0;
    localparam int unsigned REQ_DCACHE_RD = 1;
    localparam int unsigned REQ_DCACHE_WR = 2;

    typedef struct packed {
        logic               busy;
        logic [OWNER_W-1:0] owner;
        logic               we;
    } tid_entry_t;

endpackage

// File: rtl/cva6_mem_arb_tid_pool.sv
// TID pool: busy/owner/we table, lowest-free encoder and response-side lookup.
// Latency: allocation and release take effect at the next clock edge; lookup is combinational.
// Backpressure: none; the caller only allocates while free_avail_o is high.
module cva6_mem_arb_tid_pool
    import cva6_mem_arb_pkg::*;
#(
    parameter int TidWidth = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_i,
    input  logic [OWNER_W-1:0]  alloc_owner_i,
    input  logic                alloc_we_i,
    output logic                free_avail_o,
    output logic [TidWidth-1:0] free_tid_o,
    input  logic                release_i,
    input  logic [TidWidth-1:0] lookup_tid_i,
    output tid_entry_t          lookup_o,
    output logic                any_busy_o
);

    localparam int NumTids = 1 << TidWidth;

    tid_entry_t tbl_q [NumTids];
    tid_entry_t tbl_d [NumTids];

    // Encoder looks only at registered state, so a TID released this cycle is not reusable until the next.
    always_comb begin
        free_avail_o = 1'b0;
        free_tid_o   = '0;
        any_busy_o   = 1'b0;
        for (int t = NumTids - 1; t >= 0; t--) begin
            if (!tbl_q[t].busy) begin
                free_avail_o = 1'b1;
                free_tid_o   = TidWidth'(t);
            end else begin
                any_busy_o = 1'b1;
            end
        end
    end

    assign lookup_o = tbl_q[lookup_tid_i];

    always_comb begin
        tbl_d = tbl_q;
        if (release_i) begin
            tbl_d[lookup_tid_i].busy = 1'b0;
        end
        if (alloc_i) begin
            tbl_d[free_tid_o] = '{busy: 1'b1, owner: alloc_owner_i, we: alloc_we_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < NumTids; t++) begin
                tbl_q[t] <= '0;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

endmodule

// File: rtl/cva6_mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request port among NrReq requesters; responses routed by TID.
// Latency: grant to mem_req_valid_o is 1 cycle (registered); response routing is combinational.
// Backpressure: request held while mem_req_ready_i is low; grants gated by free TIDs and store limit. Counters: CVA6_MEM_ARB_PERF_EN.
module cva6_mem_req_arbiter
    import cva6_mem_arb_pkg::*;
#(
    parameter int NrReq                = 3,
    parameter int AddrWidth            = 32,
    parameter int DataWidth            = 64,
    parameter int TidWidth             = 2,
    parameter int MaxOutstandingStores = 7
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NrReq-1:0]             req_valid_i,
    output logic [NrReq-1:0]             req_ready_o,
    input  logic [NrReq-1:0]             req_we_i,
    input  logic [NrReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NrReq*DataWidth-1:0]   req_wdata_i,
    input  logic [NrReq*DataWidth/8-1:0] req_be_i,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic                         mem_req_we_o,
    output logic [AddrWidth-1:0]         mem_req_addr_o,
    output logic [DataWidth-1:0]         mem_req_wdata_o,
    output logic [DataWidth/8-1:0]       mem_req_be_o,
    output logic [TidWidth-1:0]          mem_req_tid_o,
    input  logic                         mem_rsp_valid_i,
    input  logic [TidWidth-1:0]          mem_rsp_tid_i,
    input  logic [DataWidth-1:0]         mem_rsp_rdata_i,
    input  logic                         mem_rsp_err_i,
    output logic [NrReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]         rsp_rdata_o,
    output logic                         rsp_err_o,
    output logic [TidWidth:0]            outstanding_stores_o,
    output logic                         busy_o,
    output logic                         protocol_err_o
`ifdef CVA6_MEM_ARB_PERF_EN
    ,
    output logic [NrReq*32-1:0]          stall_cnt_o,
    output logic [NrReq*32-1:0]          grant_cnt_o
`endif
);

    localparam int NumTids    = 1 << TidWidth;
    localparam int StoreLimit = (MaxOutstandingStores < NumTids) ? MaxOutstandingStores : NumTids;
    localparam int RrW        = $clog2(NrReq);
    localparam int BeWidth    = DataWidth / 8;

    logic [RrW-1:0]       rr_q, rr_d;
    logic [TidWidth:0]    st_q, st_d;
    logic                 perr_q, perr_d;
    logic                 mem_req_valid_q, mem_req_valid_d;
    logic                 mem_req_we_q, mem_req_we_d;
    logic [AddrWidth-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [DataWidth-1:0] mem_req_wdata_q, mem_req_wdata_d;
    logic [BeWidth-1:0]   mem_req_be_q, mem_req_be_d;
    logic [TidWidth-1:0]  mem_req_tid_q, mem_req_tid_d;

    logic                 free_avail;
    logic [TidWidth-1:0]  free_tid;
    tid_entry_t           rsp_entry;
    logic                 any_busy;
    logic                 slot_open;
    logic                 store_ok;
    logic                 gnt_found;
    logic [RrW-1:0]       gnt_idx;
    logic                 rsp_hit;
    logic [NrReq-1:0]     eligible;

    assign slot_open = !mem_req_valid_q || mem_req_ready_i;
    assign store_ok  = st_q < (TidWidth + 1)'(StoreLimit);
    assign eligible  = req_valid_i & ~(req_we_i & {NrReq{!store_ok}})
                     & {NrReq{free_avail && slot_open}};

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NrReq; k++) begin
            int idx;
            idx = (int'(rr_q) + k) % NrReq;
            if (!gnt_found && eligible[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = RrW'(idx);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NrReq; i++) begin
            req_ready_o[i] = gnt_found && (gnt_idx == RrW'(i));
        end
    end

    cva6_mem_arb_tid_pool #(
        .TidWidth (TidWidth)
    ) i_tid_pool (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_i       (gnt_found),
        .alloc_owner_i (OWNER_W'(gnt_idx)),
        .alloc_we_i    (req_we_i[gnt_idx]),
        .free_avail_o  (free_avail),
        .free_tid_o    (free_tid),
        .release_i     (rsp_hit),
        .lookup_tid_i  (mem_rsp_tid_i),
        .lookup_o      (rsp_entry),
        .any_busy_o    (any_busy)
    );

    always_comb begin
        mem_req_valid_d = mem_req_valid_q;
        mem_req_we_d    = mem_req_we_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        mem_req_be_d    = mem_req_be_q;
        mem_req_tid_d   = mem_req_tid_q;
        rr_d            = rr_q;
        if (gnt_found) begin
            mem_req_valid_d = 1'b1;
            mem_req_we_d    = req_we_i[gnt_idx];
            mem_req_addr_d  = req_addr_i[int'(gnt_idx)*AddrWidth +: AddrWidth];
            mem_req_wdata_d = req_wdata_i[int'(gnt_idx)*DataWidth +: DataWidth];
            mem_req_be_d    = req_be_i[int'(gnt_idx)*BeWidth +: BeWidth];
            mem_req_tid_d   = free_tid;
            rr_d            = (int'(gnt_idx) == NrReq - 1) ? '0 : gnt_idx + 1'b1;
        end else if (mem_req_ready_i) begin
            mem_req_valid_d = 1'b0;
        end
    end

    assign rsp_hit = mem_rsp_valid_i && rsp_entry.busy;

    // A write granted and a write retired in the same cycle cancel out.
    always_comb begin
        st_d = st_q;
        case ({gnt_found && req_we_i[gnt_idx], rsp_hit && rsp_entry.we})
            2'b10:   st_d = st_q + 1'b1;
            2'b01:   st_d = st_q - 1'b1;
            default: st_d = st_q;
        endcase
        perr_d = perr_q || (mem_rsp_valid_i && !rsp_entry.busy);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q            <= '0;
            st_q            <= '0;
            perr_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            mem_req_be_q    <= '0;
            mem_req_tid_q   <= '0;
        end else begin
            rr_q            <= rr_d;
            st_q            <= st_d;
            perr_q          <= perr_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            mem_req_be_q    <= mem_req_be_d;
            mem_req_tid_q   <= mem_req_tid_d;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < NrReq; i++) begin
            rsp_valid_o[i] = rsp_hit && (rsp_entry.owner == OWNER_W'(i));
        end
    end

    assign rsp_rdata_o          = mem_rsp_rdata_i;
    assign rsp_err_o            = rsp_hit && mem_rsp_err_i;
    assign mem_req_valid_o      = mem_req_valid_q;
    assign mem_req_we_o         = mem_req_we_q;
    assign mem_req_addr_o       = mem_req_addr_q;
    assign mem_req_wdata_o      = mem_req_wdata_q;
    assign mem_req_be_o         = mem_req_be_q;
    assign mem_req_tid_o        = mem_req_tid_q;
    assign outstanding_stores_o = st_q;
    assign busy_o               = any_busy || mem_req_valid_q;
    assign protocol_err_o       = perr_q;

`ifdef CVA6_MEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q [NrReq];
    logic [31:0] stall_cnt_d [NrReq];
    logic [31:0] grant_cnt_q [NrReq];
    logic [31:0] grant_cnt_d [NrReq];

    always_comb begin
        for (int i = 0; i < NrReq; i++) begin
            stall_cnt_d[i] = stall_cnt_q[i];
            grant_cnt_d[i] = grant_cnt_q[i];
            if (req_valid_i[i] && !req_ready_o[i] && (stall_cnt_q[i] != '1)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
            end
            if (req_ready_o[i] && (grant_cnt_q[i] != '1)) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
            end
            stall_cnt_o[i*32 +: 32] = stall_cnt_q[i];
            grant_cnt_o[i*32 +: 32] = grant_cnt_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrReq; i++) begin
                stall_cnt_q[i] <= '0;
                grant_cnt_q[i] <= '0;
            end
        end else begin
            stall_cnt_q <= stall_cnt_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_cva6_mem_req_arbiter.sv
// Bench for cva6_mem_req_arbiter: directed scenarios plus random traffic against a TID/store-count model.
// Expected requests and responses are queued by the driver and consumed by a negedge monitor.
`timescale 1ns/1ps
module tb_cva6_mem_req_arbiter;

    localparam int NR     = 3;
    localparam int AW     = 32;
    localparam int DW     = 64;
    localparam int BW     = DW / 8;
    localparam int TW     = 2;
    localparam int NT     = 1 << TW;
    localparam int MAX_ST = 2;
    localparam int LIMIT  = (MAX_ST < NT) ? MAX_ST : NT;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b1;
    logic [NR-1:0]      req_valid_i = '0;
    logic [NR-1:0]      req_ready_o;
    logic [NR-1:0]      req_we_i = '0;
    logic [NR*AW-1:0]   req_addr_i = '0;
    logic [NR*DW-1:0]   req_wdata_i = '0;
    logic [NR*BW-1:0]   req_be_i = '0;
    logic               mem_req_valid_o;
    logic               mem_req_ready_i = 1'b0;
    logic               mem_req_we_o;
    logic [AW-1:0]      mem_req_addr_o;
    logic [DW-1:0]      mem_req_wdata_o;
    logic [BW-1:0]      mem_req_be_o;
    logic [TW-1:0]      mem_req_tid_o;
    logic               mem_rsp_valid_i = 1'b0;
    logic [TW-1:0]      mem_rsp_tid_i = '0;
    logic [DW-1:0]      mem_rsp_rdata_i = '0;
    logic               mem_rsp_err_i = 1'b0;
    logic [NR-1:0]      rsp_valid_o;
    logic [DW-1:0]      rsp_rdata_o;
    logic               rsp_err_o;
    logic [TW:0]        outstanding_stores_o;
    logic               busy_o;
    logic               protocol_err_o;

    cva6_mem_req_arbiter #(
        .NrReq(NR), .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutstandingStores(MAX_ST)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_be_o(mem_req_be_o), .mem_req_tid_o(mem_req_tid_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_tid_i(mem_rsp_tid_i),
        .mem_rsp_rdata_i(mem_rsp_rdata_i), .mem_rsp_err_i(mem_rsp_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .outstanding_stores_o(outstanding_stores_o), .busy_o(busy_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [TW-1:0] tid;
    } req_t;

    typedef struct {
        logic [NR-1:0] vec;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    // Reference model: set of TIDs in flight with their owner and direction.
    bit            m_busy  [NT];
    int            m_owner [NT];
    bit            m_we    [NT];
    int            m_rr;
    int            m_st;
    bit            m_slot;
    bit            m_perr;
    logic [NR-1:0] exp_ready = '0;
    bit            chk_en = 1'b0;
    int            dut_grants = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_any_busy();
        bit b;
        b = 1'b0;
        for (int t = 0; t < NT; t++) b |= m_busy[t];
        return b;
    endfunction

    function automatic int lowest_busy(input bit want_we, input bit match_we);
        for (int t = 0; t < NT; t++)
            if (m_busy[t] && (!match_we || m_we[t] == want_we)) return t;
        return -1;
    endfunction

    // Called at posedge+1; returns at the next posedge+1 with the model advanced.
    task automatic drive_cycle(input logic [NR-1:0] v, input logic [NR-1:0] w, input logic rdy,
                               input logic rv, input logic [TW-1:0] rt, input logic re);
        int   lf;
        int   g;
        bit   hit;
        rsp_t r;
        req_t q;
        req_valid_i = v;
        req_we_i = w;
        mem_req_ready_i = rdy;
        for (int i = 0; i < NR; i++) begin
            req_addr_i[i*AW +: AW]  = $urandom;
            req_wdata_i[i*DW +: DW] = {$urandom, $urandom};
            req_be_i[i*BW +: BW]    = BW'($urandom);
        end
        mem_rsp_valid_i = rv;
        mem_rsp_tid_i = rt;
        mem_rsp_err_i = re;
        mem_rsp_rdata_i = {$urandom, $urandom};
        lf = -1;
        for (int t = NT - 1; t >= 0; t--) if (!m_busy[t]) lf = t;
        g = -1;
        if (lf >= 0 && (!m_slot || rdy)) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_rr + k) % NR;
                if (g < 0 && v[j] && (!w[j] || m_st < LIMIT)) g = j;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        hit = rv && m_busy[rt];
        if (rv) begin
            r.vec = '0;
            if (hit) r.vec[m_owner[rt]] = 1'b1;
            r.err = hit && re;
            r.rdata = mem_rsp_rdata_i;
            rsp_q.push_back(r);
        end
        @(posedge clk_i);
        if (rv) begin
            if (hit) begin
                m_busy[rt] = 1'b0;
                if (m_we[rt]) m_st--;
            end else begin
                m_perr = 1'b1;
            end
        end
        if (g >= 0) begin
            q.we = w[g];
            q.addr = req_addr_i[g*AW +: AW];
            q.wdata = req_wdata_i[g*DW +: DW];
            q.be = req_be_i[g*BW +: BW];
            q.tid = TW'(lf);
            req_q.push_back(q);
            m_busy[lf] = 1'b1;
            m_owner[lf] = g;
            m_we[lf] = w[g];
            if (w[g]) m_st++;
            m_rr = (g + 1) % NR;
            m_slot = 1'b1;
        end else if (rdy) begin
            m_slot = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        req_valid_i = '0;
        req_we_i = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_rdata_i = '0;
        mem_rsp_err_i = 1'b0;
        rst_ni = 1'b0;
        #2;
        check("rst_mem_req_valid", 64'(mem_req_valid_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_outstanding", 64'(outstanding_stores_o), 64'(0));
        check("rst_protocol_err", 64'(protocol_err_o), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_req_ready", 64'(req_ready_o), 64'(0));
        check("rst_mem_req_tid", 64'(mem_req_tid_o), 64'(0));
        for (int t = 0; t < NT; t++) begin
            m_busy[t] = 1'b0;
            m_owner[t] = 0;
            m_we[t] = 1'b0;
        end
        m_rr = 0;
        m_st = 0;
        m_slot = 1'b0;
        m_perr = 1'b0;
        exp_ready = '0;
        req_q.delete();
        rsp_q.delete();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic drain();
        for (int n = 0; n < NT + 2; n++) begin
            int t;
            t = lowest_busy(1'b0, 1'b0);
            if (t >= 0) drive_cycle('0, '0, 1'b1, 1'b1, TW'(t), 1'($urandom_range(0, 1)));
            else drive_cycle('0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("req_ready", 64'(req_ready_o), 64'(exp_ready));
            if (|req_ready_o) dut_grants++;
            check("mem_req_valid", 64'(mem_req_valid_o), 64'(m_slot));
            check("outstanding_stores", 64'(outstanding_stores_o), 64'(m_st));
            check("busy", 64'(busy_o), 64'(model_any_busy() || m_slot));
            check("protocol_err", 64'(protocol_err_o), 64'(m_perr));
            if (mem_req_valid_o) begin
                if (req_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mem_req_unexpected: got valid request tid %0d, expected none", mem_req_tid_o);
                end else begin
                    check("mem_req_we", 64'(mem_req_we_o), 64'(req_q[0].we));
                    check("mem_req_addr", 64'(mem_req_addr_o), 64'(req_q[0].addr));
                    check("mem_req_wdata", 64'(mem_req_wdata_o), 64'(req_q[0].wdata));
                    check("mem_req_be", 64'(mem_req_be_o), 64'(req_q[0].be));
                    check("mem_req_tid", 64'(mem_req_tid_o), 64'(req_q[0].tid));
                    if (mem_req_ready_i) void'(req_q.pop_front());
                end
            end
            if (mem_rsp_valid_i && rsp_q.size() != 0) begin
                rsp_t r;
                r = rsp_q.pop_front();
                check("rsp_valid", 64'(rsp_valid_o), 64'(r.vec));
                check("rsp_err", 64'(rsp_err_o), 64'(r.err));
                check("rsp_rdata", 64'(rsp_rdata_o), 64'(r.rdata));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 1ms");
        $fatal(1);
    end

    initial begin
        int t;
        int t2;
        #1;
        do_reset();

        // Single icache read, then its response while the request drains.
        drive_cycle(3'b001, '0, 1'b1, 1'b0, '0, 1'b0);
        check("t1_tid", 64'(mem_req_tid_o), 64'(0));
        check("t1_valid", 64'(mem_req_valid_o), 64'(1));
        drive_cycle('0, '0, 1'b1, 1'b1, '0, 1'b0);
        drain();

        // All requesters valid with immediate responses.
        for (int c = 0; c < 24; c++) begin
            t = lowest_busy(1'b0, 1'b0);
            drive_cycle(3'b111, '0, 1'b1, t >= 0, TW'(t < 0 ? 0 : t), 1'($urandom_range(0, 1)));
        end
        drain();

        // TID exhaustion: 4 reads granted, the 5th waits until one TID is released.
        dut_grants = 0;
        for (int c = 0; c < 6; c++) drive_cycle(3'b010, '0, 1'b1, 1'b0, '0, 1'b0);
        check("t3_grants_exhaust", 64'(dut_grants), 64'(4));
        drive_cycle(3'b010, '0, 1'b1, 1'b1, '0, 1'b0);
        drive_cycle(3'b010, '0, 1'b1, 1'b0, '0, 1'b0);
        check("t3_grants_after_free", 64'(dut_grants), 64'(5));
        drain();

        // Store limit: writes stop at the limit while reads keep being granted.
        dut_grants = 0;
        for (int c = 0; c < 8; c++) drive_cycle(3'b110, 3'b100, 1'b1, 1'b0, '0, 1'b0);
        check("t4_store_limit", 64'(outstanding_stores_o), 64'(LIMIT));
        check("t4_total_grants", 64'(dut_grants), 64'(4));
        t = lowest_busy(1'b1, 1'b1);
        drive_cycle('0, '0, 1'b1, 1'b1, TW'(t < 0 ? 0 : t), 1'b0);
        t2 = lowest_busy(1'b1, 1'b1);
        drive_cycle(3'b100, 3'b100, 1'b1, 1'b1, TW'(t2 < 0 ? 0 : t2), 1'b0);
        check("t4_grant_and_rsp_same_cycle", 64'(outstanding_stores_o), 64'(LIMIT - 1));
        drain();

        // Downstream stall for 5 cycles, then a response for an unused TID.
        dut_grants = 0;
        for (int c = 0; c < 6; c++) drive_cycle(3'b011, '0, 1'b0, 1'b0, '0, 1'b0);
        check("t5_stall_grants", 64'(dut_grants), 64'(1));
        check("t5_stall_ready", 64'(req_ready_o), 64'(0));
        drive_cycle('0, '0, 1'b1, 1'b1, TW'(NT - 1), 1'b1);
        check("t5_protocol_err", 64'(protocol_err_o), 64'(1));
        drain();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            int cnt;
            int pick;
            logic [TW-1:0] rt;
            bit rv;
            cnt = 0;
            for (int k = 0; k < NT; k++) if (m_busy[k]) cnt++;
            rv = 1'b0;
            rt = '0;
            if (cnt > 0 && $urandom_range(0, 2) != 0) begin
                pick = $urandom_range(0, cnt - 1);
                for (int k = 0; k < NT; k++) begin
                    if (m_busy[k]) begin
                        if (pick == 0) begin
                            rt = TW'(k);
                            rv = 1'b1;
                        end
                        pick--;
                    end
                end
            end
            drive_cycle(NR'($urandom), NR'($urandom), $urandom_range(0, 3) != 0, rv, rt,
                        $urandom_range(0, 7) == 0);
        end

        // Reset with TIDs in flight; the first grant afterwards gets TID 0.
        for (int c = 0; c < 3; c++) drive_cycle(3'b001, '0, 1'b1, 1'b0, '0, 1'b0);
        check("t6_busy_before_reset", 64'(busy_o), 64'(1));
        do_reset();
        drive_cycle(3'b001, '0, 1'b1, 1'b0, '0, 1'b0);
        check("t6_post_reset_tid", 64'(mem_req_tid_o), 64'(0));
        drain();
        check("leftover_requests", 64'(req_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
